vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, giving the active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, giving the horizontal front-porch clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, giving the horizontal sync-pulse clocks.
REQ-004 The block SHALL have parameter H_BACK, default 48, giving the horizontal back-porch clocks.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, giving the active lines per frame.
REQ-006 The block SHALL have parameters V_FRONT, V_SYNC and V_BACK, defaults 10, 2 and 33, giving the vertical porch and sync lines.
REQ-007 The block SHALL have port vga_clk, input, 1 bit: the single clock; all flops SHALL sample on its rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port DrawX, output, 10 bits: the current horizontal counter.
REQ-010 The block SHALL have port DrawY, output, 10 bits: the current vertical counter.
REQ-011 The block SHALL have port hs, output, 1 bit: horizontal sync, active-low.
REQ-012 The block SHALL have port vs, output, 1 bit: vertical sync, active-low.
REQ-013 The block SHALL have port blank, output, 1 bit: display-enable, 1 = visible region, 0 = porch or sync.
REQ-014 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse on entry to (0,0).
REQ-015 The block SHALL have port pixel_tick, output, 1 bit: high on cycles where the counters advance.

Function
REQ-016 HTOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800), and VTOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-017 On each advance, DrawX SHALL increment and wrap from HTOTAL-1 to 0.
REQ-018 On the advance that wraps DrawX, DrawY SHALL increment and wrap from VTOTAL-1 to 0; DrawY SHALL be unchanged otherwise.
REQ-019 hs SHALL be 0 exactly when DrawX is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751), and 1 otherwise.
REQ-020 vs SHALL be 0 exactly when DrawY is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491), and 1 otherwise.
REQ-021 blank SHALL be 1 exactly when DrawX<H_VISIBLE and DrawY<V_VISIBLE.
REQ-022 hs, vs, blank and frame_start SHALL be registered and cycle-aligned with the DrawX/DrawY values they describe; decoding SHALL be done from next-state counter values, so there is zero lag.
REQ-023 frame_start SHALL be 1 for exactly one cycle, the cycle in which the counters first hold (0,0) after advancing from (HTOTAL-1, VTOTAL-1).
REQ-024 Counters SHALL never hold values ≥ HTOTAL or ≥ VTOTAL.
REQ-025 Counter width SHALL be 10 bits; the parameter sums SHALL NOT exceed 1024.

Reset
REQ-026 While reset_n=0, outputs SHALL be forced asynchronously to DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, and pixel_tick=0.
REQ-027 Assertion of reset_n mid-frame SHALL abandon the frame with no further frame_start pulse.
REQ-028 After reset_n deasserts, counting SHALL resume from (0,0); the first frame SHALL produce no frame_start at (0,0).

Configuration
REQ-029 If macro VGA_PIX_DIV2_EN is defined, an internal phase flop SHALL toggle every clock, with reset value 0.
REQ-030 With VGA_PIX_DIV2_EN defined, pixel_tick SHALL equal phase, and counters SHALL advance only on cycles where phase=1; all outputs SHALL hold between advances, and frame_start SHALL last 2 clocks.
REQ-031 With VGA_PIX_DIV2_EN defined, the first advance SHALL occur on the 2nd rising edge after reset release.
REQ-032 If VGA_PIX_DIV2_EN is undefined, pixel_tick SHALL be 1 out of reset, and counters SHALL advance every clock after reset release.

Verification
REQ-033 Release reset and run 800 clocks (macro off) -> DrawX sequence 0..799 then 0; DrawY goes 0->1 on the wrap; blank falls at DrawX=640.
REQ-034 Run one full line -> hs=0 for exactly 96 clocks, starting when DrawX=656; blank=1 for exactly 640 clocks.
REQ-035 Run 2 frames (2x420000 clocks) -> exactly one frame_start pulse, at clock 420000; vs=0 for exactly 1600 clocks, starting at DrawY=490, DrawX=0.
REQ-036 Assert reset_n=0 asynchronously at DrawX=300, DrawY=200 -> all outputs take reset values immediately, without a clock edge; after release, counting restarts at (0,0).
REQ-037 Run with VGA_PIX_DIV2_EN defined for 1600 clocks -> each DrawX value held for 2 clocks; DrawY=1 at clock 1600; pixel_tick alternates 0,1.
REQ-038 Run with parameters H_VISIBLE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> DrawX wraps at 13 and DrawY wraps at 6; hs=0 when DrawX is 10..11; frame_start period is 98 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with sync, blank and frame_start decoded from next-state counts.
// Optional VGA_PIX_DIV2_EN: counters advance every other clock, pixel_tick = phase. Totals must not exceed 1024.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic       pixel_tick
);

  localparam int HTOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(VTOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       fs_q, fs_d;
  logic       advance;

`ifdef VGA_PIX_DIV2_EN
  logic phase_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) phase_q <= 1'b0;
    else          phase_q <= ~phase_q;
  end

  assign advance    = phase_q;
  assign pixel_tick = phase_q;
`else
  // Every clock is a pixel clock; tick drops with reset without needing an edge.
  assign advance    = 1'b1;
  assign pixel_tick = reset_n;
`endif

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fs_d = fs_q;
    if (advance) begin
      fs_d = 1'b0;
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Decoding the next-state counts keeps the registered flags aligned with DrawX/DrawY.
  assign hs_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
  assign vs_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
  assign blank_d = (x_d < H_VIS) && (y_d < V_VIS);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default-timing and small-timing instances against an arithmetic raster model.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n;
  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic       pt;
  } obs_t;

  logic [9:0] x0, y0, x1, y1;
  logic hs0, vs0, bl0, fs0, pt0, hs1, vs1, bl1, fs1, pt1;

  vga_timing_gen u_dflt (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x0), .DrawY(y0), .hs(hs0), .vs(vs0),
    .blank(bl0), .frame_start(fs0), .pixel_tick(pt0)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x1), .DrawY(y1), .hs(hs1), .vs(vs1),
    .blank(bl1), .frame_start(fs1), .pixel_tick(pt1)
  );

  obs_t act0, act1;
  assign act0 = {x0, y0, hs0, vs0, bl0, fs0, pt0};
  assign act1 = {x1, y1, hs1, vs1, bl1, fs1, pt1};

  obs_t q0[$];
  obs_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  // n = number of advances since reset release; position follows from plain division.
  function automatic obs_t model(int n, logic pt, int hv, int hf, int hsy, int hb,
                                 int vv, int vf, int vsy, int vb);
    obs_t o;
    int ht = hv + hf + hsy + hb;
    int vt = vv + vf + vsy + vb;
    int x  = n % ht;
    int y  = (n / ht) % vt;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.hs    = !(x >= hv + hf && x < hv + hf + hsy);
    o.vs    = !(y >= vv + vf && y < vv + vf + vsy);
    o.blank = (x < hv) && (y < vv);
    o.fs    = (n > 0) && (x == 0) && (y == 0);
    o.pt    = pt;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.x = '0; o.y = '0; o.hs = 1'b1; o.vs = 1'b1; o.blank = 1'b1; o.fs = 1'b0; o.pt = 1'b0;
    return o;
  endfunction

  task automatic cmp(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b pt=%b required x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b pt=%b",
               name, $time, a.x, a.y, a.hs, a.vs, a.blank, a.fs, a.pt,
               e.x, e.y, e.hs, e.vs, e.blank, e.fs, e.pt);
    end
  endtask

  task automatic step();
    int   n;
    logic pt;
    @(posedge vga_clk);
    if (reset_n) begin
      edges++;
`ifdef VGA_PIX_DIV2_EN
      n  = edges / 2;
      pt = 1'((edges % 2) == 1);
`else
      n  = edges;
      pt = 1'b1;
`endif
      q0.push_back(model(n, pt, 640, 16, 96, 48, 480, 10, 2, 33));
      q1.push_back(model(n, pt, 8, 2, 2, 2, 4, 1, 1, 1));
    end else begin
      q0.push_back(reset_obs());
      q1.push_back(reset_obs());
    end
  endtask

  // Reset is asserted mid-cycle; outputs must already be at reset values 1ns later.
  task automatic assert_rst();
    @(negedge vga_clk);
    #2;
    reset_n = 1'b0;
    edges   = 0;
    #1;
    cmp("async_rst_dflt", act0, reset_obs());
    cmp("async_rst_small", act1, reset_obs());
  endtask

  task automatic release_rst();
    @(negedge vga_clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    obs_t e;
    forever begin
      @(negedge vga_clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("raster_dflt", act0, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("raster_small", act1, e);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) step();
    release_rst();
    repeat (1700) step();
    for (int s = 0; s < 6; s++) begin
      repeat ($urandom_range(40, 1200)) step();
      assert_rst();
      repeat ($urandom_range(1, 3)) step();
      release_rst();
    end
    repeat (300) step();
    @(negedge vga_clk);
    @(negedge vga_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
